// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the CPU core and the host port.
package dmem_arb_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      WAIT = 1'b1
   } arb_state_t;

   localparam int         STARVE_LIM_DEF = 16;
   // Core addresses at or above this go to temp memory before reaching the arbiter.
   localparam logic [7:0] TEMP_MEM_ADDR  = 8'h80;

endpackage

// File: rtl/arb_wait_cnt.sv
// Saturating up-counter tracking how long the host has been kept waiting.
module arb_wait_cnt #(
   parameter int LIMIT = 16
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       inc,
   input  logic                       clr,
   output logic [$clog2(LIMIT+1)-1:0] cnt,
   output logic                       sat
);

   localparam int CW = $clog2(LIMIT+1);
   localparam logic [CW-1:0] LIM = CW'(LIMIT);

   assign sat = (cnt == LIM);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         cnt <= '0;
      else if (clr)
         cnt <= '0;
      else if (inc && !sat)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data_mem arbiter: core has absolute priority, host fills idle/halted cycles.
// Optional ARB_STALL_EN: a starved host may stall the core for one cycle to get its access.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW         = 8,
   parameter int DW         = 8,
   parameter int STARVE_LIM = STARVE_LIM_DEF
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          core_rd,
   input  logic          core_wr,
   input  logic [AW-1:0] core_addr,
   input  logic [DW-1:0] core_wdata,
   input  logic          core_halted,
   output logic          core_stall,
   input  logic          host_req,
   input  logic          host_we,
   input  logic [AW-1:0] host_addr,
   input  logic [DW-1:0] host_wdata,
   output logic          host_gnt,
   output logic          host_rvalid,
   output logic [DW-1:0] host_rdata,
   output logic          host_starve,
   output logic          mem_rd,
   output logic          mem_wr,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam int CW = $clog2(STARVE_LIM+1);

   arb_state_t    state, state_nxt;
   logic [CW-1:0] wait_cnt;
   logic          core_use;
   logic          force_gnt;

   assign core_use = (core_rd | core_wr) & ~core_halted;

`ifdef ARB_STALL_EN
   assign force_gnt = host_starve & core_use & host_req;
`else
   assign force_gnt = 1'b0;
`endif

   assign host_gnt   = host_req & (~core_use | force_gnt);
   assign core_stall = force_gnt;

   // A host grant suppresses the core access entirely, including a forced one.
   always_comb begin
      mem_rd    = core_rd & ~core_halted;
      mem_wr    = core_wr & ~core_halted;
      mem_addr  = core_addr;
      mem_wdata = core_wdata;
      if (host_gnt) begin
         mem_rd    = ~host_we;
         mem_wr    = host_we;
         mem_addr  = host_addr;
         mem_wdata = host_wdata;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (host_req && !host_gnt) state_nxt = WAIT;
         WAIT:    if (host_gnt || !host_req) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   arb_wait_cnt #(.LIMIT(STARVE_LIM)) u_wait_cnt (
      .clk     (clk),
      .reset_n (reset_n),
      .inc     (host_req & ~host_gnt),
      .clr     (host_gnt | ~host_req),
      .cnt     (wait_cnt),
      .sat     (host_starve)
   );

   // Read response is a flag beside the FSM so a new grant can overlap it.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         host_rvalid <= 1'b0;
         host_rdata  <= '0;
      end else begin
         host_rvalid <= host_gnt & ~host_we;
         if (host_gnt && !host_we)
            host_rdata <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized traffic vs a reference model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int LIM = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       core_rd, core_wr, core_halted, core_stall;
   logic [7:0] core_addr, core_wdata;
   logic       host_req, host_we, host_gnt, host_rvalid, host_starve;
   logic [7:0] host_addr, host_wdata, host_rdata;
   logic       mem_rd, mem_wr;
   logic [7:0] mem_addr, mem_wdata, mem_rdata;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   int         m_waited;
   logic       m_rvalid;
   logic [7:0] m_rdata;
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.AW(8), .DW(8), .STARVE_LIM(LIM)) u_dut (
      .clk(clk), .reset_n(reset_n),
      .core_rd(core_rd), .core_wr(core_wr), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_halted(core_halted), .core_stall(core_stall),
      .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
      .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
      .host_starve(host_starve),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // data_mem stand-in: synchronous write, combinational read
   always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;
   assign mem_rdata = mem[mem_addr];

   function automatic logic ref_core_use();
      return (core_rd | core_wr) & ~core_halted;
   endfunction

   function automatic logic ref_force();
      logic f = 1'b0;
`ifdef ARB_STALL_EN
      f = (m_waited == LIM) && ref_core_use() && host_req;
`endif
      return f;
   endfunction

   function automatic logic ref_gnt();
      return host_req & (~ref_core_use() | ref_force());
   endfunction

   function automatic logic [17:0] ref_mem_bus();
      if (ref_gnt()) return {~host_we, host_we, host_addr, host_wdata};
      return {core_rd & ~core_halted, core_wr & ~core_halted, core_addr, core_wdata};
   endfunction

   task automatic model_reset();
      m_waited = 0;
      m_rvalid = 1'b0;
      m_rdata  = 8'h00;
   endtask

   // Advance one clock, updating the model from the inputs held across the edge.
   task automatic tick();
      logic g;
      g = ref_gnt();
      @(posedge clk);
      m_rvalid = g & ~host_we;
      if (m_rvalid) m_rdata = ref_mem[host_addr];
      if (g && host_we) ref_mem[host_addr] = host_wdata;
      else if (!g && core_wr && !core_halted) ref_mem[core_addr] = core_wdata;
      m_waited = (host_req && !g) ? ((m_waited < LIM) ? m_waited + 1 : LIM) : 0;
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      core_rd = 0; core_wr = 0; core_halted = 0; core_addr = 0; core_wdata = 0;
      host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      host_req = 1; host_addr = 8'h07;
      reset_n = 0;
      model_reset();
      repeat (2) @(negedge clk);
      #1;
      checks++; if (host_rvalid !== 1'b0 || host_rdata !== 8'h00)
         begin errors++; $display("FAIL reset_resp: rvalid=%b rdata=%h want 0/00", host_rvalid, host_rdata); end
      checks++; if (host_starve !== 1'b0 || core_stall !== 1'b0)
         begin errors++; $display("FAIL reset_flags: starve=%b stall=%b want 0/0", host_starve, core_stall); end
      checks++; if (host_gnt !== 1'b1 || mem_addr !== 8'h07)
         begin errors++; $display("FAIL reset_comb: gnt=%b addr=%h want 1/07", host_gnt, mem_addr); end
      host_req = 0;
      @(negedge clk);
      reset_n = 1;
      tick();
   endtask

   task automatic test_host_rw();
      host_req = 1; host_we = 1; host_addr = 8'h10; host_wdata = 8'hA5;
      #1;
      checks++; if (host_gnt !== 1'b1 || mem_wr !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 8'hA5)
         begin errors++; $display("FAIL hw_gnt: gnt=%b wr=%b addr=%h d=%h want 1/1/10/a5", host_gnt, mem_wr, mem_addr, mem_wdata); end
      tick();
      host_we = 0;
      #1;
      checks++; if (host_gnt !== 1'b1 || mem_rd !== 1'b1 || host_rvalid !== 1'b0)
         begin errors++; $display("FAIL hr_gnt: gnt=%b rd=%b rvalid=%b want 1/1/0", host_gnt, mem_rd, host_rvalid); end
      tick();
      host_req = 0;
      #1;
      checks++; if (host_rvalid !== 1'b1 || host_rdata !== 8'hA5)
         begin errors++; $display("FAIL hr_data: rvalid=%b rdata=%h want 1/a5", host_rvalid, host_rdata); end
      tick();
      checks++; if (host_rvalid !== 1'b0)
         begin errors++; $display("FAIL hr_once: rvalid=%b want 0", host_rvalid); end
   endtask

   task automatic test_core_priority();
      host_req = 1; host_we = 0; host_addr = 8'h10;
      core_rd = 1;
      for (int i = 0; i < 5; i++) begin
         core_addr = 8'(8'h30 + i);
         #1;
         checks++; if (host_gnt !== 1'b0 || mem_addr !== core_addr || mem_rd !== 1'b1)
            begin errors++; $display("FAIL prio_c%0d: gnt=%b addr=%h want 0/%h", i, host_gnt, mem_addr, core_addr); end
         tick();
      end
      core_rd = 0;
      #1;
      checks++; if (host_gnt !== 1'b1 || mem_addr !== 8'h10)
         begin errors++; $display("FAIL prio_c5: gnt=%b addr=%h want 1/10", host_gnt, mem_addr); end
      tick();
      host_req = 0;
      #1;
      checks++; if (host_rvalid !== 1'b1 || host_rdata !== m_rdata)
         begin errors++; $display("FAIL prio_data: rvalid=%b rdata=%h want 1/%h", host_rvalid, host_rdata, m_rdata); end
      tick();
   endtask

   task automatic test_starve();
      logic g;
      logic exp_g, exp_s, exp_st;
      core_wr = 1; core_addr = 8'h41; core_wdata = 8'h99;
      host_req = 1; host_we = 1; host_addr = 8'h40; host_wdata = 8'h5A;
      for (int i = 0; i < 20; i++) begin
         #1;
`ifdef ARB_STALL_EN
         exp_g = (i == 16); exp_s = (i == 16); exp_st = (i == 16);
`else
         exp_g = 1'b0; exp_s = (i >= 16); exp_st = 1'b0;
`endif
         checks++; if (host_gnt !== exp_g || host_starve !== exp_s || core_stall !== exp_st)
            begin errors++; $display("FAIL starve_c%0d: gnt=%b starve=%b stall=%b want %b/%b/%b", i, host_gnt, host_starve, core_stall, exp_g, exp_s, exp_st); end
         if (exp_g) begin
            checks++; if (mem_wr !== 1'b1 || mem_addr !== 8'h40 || mem_wdata !== 8'h5A)
               begin errors++; $display("FAIL starve_force: wr=%b addr=%h d=%h want 1/40/5a", mem_wr, mem_addr, mem_wdata); end
         end
         g = host_gnt;
         tick();
         if (g) host_req = 0;
      end
      core_wr = 0;
      #1;
`ifdef ARB_STALL_EN
      exp_g = 1'b0;
`else
      exp_g = 1'b1;
`endif
      checks++; if (host_gnt !== exp_g)
         begin errors++; $display("FAIL starve_idle: gnt=%b want %b", host_gnt, exp_g); end
      tick();
      host_req = 0;
      tick();
      checks++; if (mem[8'h40] !== 8'h5A || mem[8'h41] !== 8'h99)
         begin errors++; $display("FAIL starve_mem: m40=%h m41=%h want 5a/99", mem[8'h40], mem[8'h41]); end
   endtask

   task automatic test_halted();
      core_halted = 1; core_wr = 1; core_addr = 8'h20; core_wdata = 8'h77;
      host_req = 1; host_we = 1; host_addr = 8'h20; host_wdata = 8'h3C;
      #1;
      checks++; if (host_gnt !== 1'b1 || mem_wdata !== 8'h3C)
         begin errors++; $display("FAIL halt_gnt: gnt=%b d=%h want 1/3c", host_gnt, mem_wdata); end
      tick();
      host_req = 0;
      #1;
      checks++; if (mem_wr !== 1'b0 || mem_rd !== 1'b0)
         begin errors++; $display("FAIL halt_mask: wr=%b rd=%b want 0/0", mem_wr, mem_rd); end
      tick();
      checks++; if (mem[8'h20] !== 8'h3C)
         begin errors++; $display("FAIL halt_mem: m20=%h want 3c", mem[8'h20]); end
      idle_inputs();
   endtask

   task automatic test_reset_rvalid();
      host_req = 1; host_we = 0; host_addr = 8'h10;
      tick();
      host_req = 0;
      #1;
      checks++; if (host_rvalid !== 1'b1)
         begin errors++; $display("FAIL rst_pre: rvalid=%b want 1", host_rvalid); end
      reset_n = 0;
      #1;
      checks++; if (host_rvalid !== 1'b0 || host_rdata !== 8'h00 || u_dut.wait_cnt !== 5'd0)
         begin errors++; $display("FAIL rst_async: rvalid=%b rdata=%h cnt=%0d want 0/00/0", host_rvalid, host_rdata, u_dut.wait_cnt); end
      model_reset();
      @(negedge clk);
      reset_n = 1;
      tick();
      checks++; if (u_dut.state !== IDLE || host_rvalid !== 1'b0)
         begin errors++; $display("FAIL rst_idle: state=%0d rvalid=%b want IDLE/0", u_dut.state, host_rvalid); end
   endtask

   task automatic test_drop();
      core_rd = 1; core_addr = 8'h50;
      host_req = 1; host_we = 0; host_addr = 8'h51;
      repeat (5) tick();
      checks++; if (u_dut.wait_cnt !== 5'd5 || u_dut.state !== WAIT)
         begin errors++; $display("FAIL drop_wait: cnt=%0d state=%0d want 5/WAIT", u_dut.wait_cnt, u_dut.state); end
      host_req = 0;
      #1;
      checks++; if (host_gnt !== 1'b0)
         begin errors++; $display("FAIL drop_gnt: gnt=%b want 0", host_gnt); end
      tick();
      checks++; if (u_dut.wait_cnt !== 5'd0 || u_dut.state !== IDLE || host_rvalid !== 1'b0)
         begin errors++; $display("FAIL drop_idle: cnt=%0d state=%0d rvalid=%b want 0/IDLE/0", u_dut.wait_cnt, u_dut.state, host_rvalid); end
      idle_inputs();
   endtask

   task automatic test_random();
      logic last_g = 1'b1;
      int   bad = 0;
      for (int i = 0; i < 400; i++) begin
         if (!host_req || last_g) begin
            host_req   = ($urandom_range(0, 2) != 0);
            host_we    = $urandom_range(0, 1);
            host_addr  = 8'($urandom_range(0, 15));
            host_wdata = 8'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            host_req = 0;
         end
         case ($urandom_range(0, 2))
            0: begin core_rd = 0; core_wr = 0; end
            1: begin core_rd = 1; core_wr = 0; end
            default: begin core_rd = 0; core_wr = 1; end
         endcase
         core_halted = ($urandom_range(0, 7) == 0);
         core_addr   = 8'($urandom_range(0, 15));
         core_wdata  = 8'($urandom);
         #1;
         checks++; if (host_gnt !== ref_gnt() || core_stall !== ref_force() || host_starve !== (m_waited == LIM))
            begin errors++; $display("FAIL rnd_ctl@%0d: gnt=%b stall=%b starve=%b want %b/%b/%b", i, host_gnt, core_stall, host_starve, ref_gnt(), ref_force(), m_waited == LIM); end
         checks++; if ({mem_rd, mem_wr, mem_addr, mem_wdata} !== ref_mem_bus())
            begin errors++; $display("FAIL rnd_mem@%0d: bus=%h want %h", i, {mem_rd, mem_wr, mem_addr, mem_wdata}, ref_mem_bus()); end
         checks++; if (host_rvalid !== m_rvalid || host_rdata !== m_rdata)
            begin errors++; $display("FAIL rnd_resp@%0d: rvalid=%b rdata=%h want %b/%h", i, host_rvalid, host_rdata, m_rvalid, m_rdata); end
         last_g = host_gnt;
         tick();
      end
      idle_inputs();
      for (int a = 0; a < 256; a++) if (mem[a] !== ref_mem[a]) bad++;
      checks++; if (bad != 0)
         begin errors++; $display("FAIL rnd_memimg: %0d differing bytes want 0", bad); end
   endtask

   initial begin
      for (int a = 0; a < 256; a++) begin mem[a] = 8'h00; ref_mem[a] = 8'h00; end
      test_reset();
      test_host_rw();
      test_core_priority();
      test_starve();
      test_halted();
      test_reset_rvalid();
      test_drop();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
